// File: rtl/deserq_pkg.sv
// Shared types and default sizes for the parametrised serial word queue.
package deserq_pkg;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } deserq_state_t;

  localparam int DESERQ_DEF_WIDTH = 8;
  localparam int DESERQ_DEF_DEPTH = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO. The head word is visible whenever the FIFO is non-empty
// and reads as zero when it is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the cleared count masks stale entries, so
  // the array maps onto plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/deser_queue_param.sv
// Serial-in deserializer feeding a DEPTH-entry queue; a completed word stalls in a hold
// register while the queue is full. Optional even-parity framing: DESERQ_PARITY_EN.
module deser_queue_param
  import deserq_pkg::*;
#(
  parameter int WIDTH     = DESERQ_DEF_WIDTH,
  parameter int DEPTH     = DESERQ_DEF_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clock1M,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       status_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow,
  output logic                       parity_err
);

`ifdef DESERQ_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int BIT_W = $clog2(FRAME);

  deserq_state_t    state_q, state_d;
  logic             write_q, deq_q;
  logic             bit_stb, pop_stb;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_word, final_word;
  logic             last_bit, frame_ok;
  logic             push;
  logic [WIDTH-1:0] push_word;
  logic             ovf_d, ovf_q;
`ifdef DESERQ_PARITY_EN
  logic             perr_d, perr_q;
`endif

  assign bit_stb  = write_in & ~write_q;
  assign pop_stb  = dequeue_in & ~deq_q;
  assign last_bit = (bit_cnt_q == BIT_W'(FRAME - 1));

  assign shift_word = MSB_FIRST ? {sr_q[WIDTH-2:0], data_in} : {data_in, sr_q[WIDTH-1:1]};

`ifdef DESERQ_PARITY_EN
  // The closing bit is even parity over the already-shifted word.
  assign final_word = sr_q;
  assign frame_ok   = ((^sr_q) == data_in);
`else
  assign final_word = shift_word;
  assign frame_ok   = 1'b1;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock1M) begin
    if (!reset) begin
      state_q   <= S_COLLECT;
      write_q   <= 1'b0;
      deq_q     <= 1'b0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      hold_q    <= '0;
      ovf_q     <= 1'b0;
`ifdef DESERQ_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      write_q   <= write_in;
      deq_q     <= dequeue_in;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      ovf_q     <= ovf_d;
`ifdef DESERQ_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_word = hold_q;
    ovf_d     = 1'b0;
`ifdef DESERQ_PARITY_EN
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_COLLECT: begin
        if (bit_stb) begin
          if (last_bit) begin
            bit_cnt_d = '0;
            // A same-cycle pop frees a slot, so a full queue can still accept.
            if (frame_ok && (!full_out || pop_stb)) begin
              push      = 1'b1;
              push_word = final_word;
            end else if (frame_ok) begin
              hold_d  = final_word;
              state_d = S_HOLD;
            end
`ifdef DESERQ_PARITY_EN
            else begin
              perr_d = 1'b1;
            end
`endif
          end else begin
            sr_d      = shift_word;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_HOLD: begin
        ovf_d = bit_stb;
        if (pop_stb) begin
          push    = 1'b1;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock1M),
    .rst_n     (reset),
    .push      (push),
    .pop       (pop_stb),
    .push_data (push_word),
    .head      (data_out),
    .count     (count_out),
    .full      (full_out),
    .empty     (empty_out)
  );

  assign status_out = (state_q == S_HOLD);
  assign overflow   = ovf_q;
`ifdef DESERQ_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deser_queue_param.sv
// Bench for deser_queue_param (DEPTH=4): table-driven frames, hand sequences for the
// full/HOLD/reset/framing corners, then random traffic against a queue-based model.
module tb_deser_queue_param;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
`ifdef DESERQ_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic          clock1M = 1'b0;
  logic          reset = 1'b0;
  logic          data_in = 1'b0;
  logic          write_in = 1'b0;
  logic          dequeue_in = 1'b0;
  logic [W-1:0]  data_out;
  logic          status_out;
  logic [CW-1:0] count_out;
  logic          full_out, empty_out, overflow, parity_err;

  always #5 clock1M = ~clock1M;

  deser_queue_param #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut (
    .clock1M    (clock1M),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .dequeue_in (dequeue_in),
    .data_out   (data_out),
    .status_out (status_out),
    .count_out  (count_out),
    .full_out   (full_out),
    .empty_out  (empty_out),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: words live in a queue, frame bits in a bit list.
  logic [W-1:0] m_q[$];
  bit           m_bits[$];
  logic [W-1:0] m_held;
  bit           m_hold, m_pw, m_pd, m_ovf, m_perr;
  bit           ovf_seen, perr_seen;

  function automatic void model_step();
    bit bs, ps, word_ready, ok;
    int size0;
    logic [W-1:0] w;
    if (!reset) begin
      m_q.delete(); m_bits.delete();
      m_hold = 0; m_pw = 0; m_pd = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    bs = write_in && !m_pw;
    ps = dequeue_in && !m_pd;
    m_pw = write_in; m_pd = dequeue_in;
    m_ovf = 0; m_perr = 0;
    size0 = m_q.size();
    if (m_hold) begin
      if (bs) m_ovf = 1;
      if (ps) begin
        void'(m_q.pop_front());
        m_q.push_back(m_held);
        m_hold = 0;
      end
      return;
    end
    word_ready = 0; ok = 1; w = '0;
    if (bs) begin
      m_bits.push_back(data_in);
      if (m_bits.size() == FRAME) begin
        for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
        if (FRAME > W) ok = (m_bits[W] == (^w));
        m_bits.delete();
        word_ready = 1;
      end
    end
    if (ps && size0 > 0) void'(m_q.pop_front());
    if (word_ready) begin
      if (!ok) m_perr = 1;
      else if (size0 < D || ps) m_q.push_back(w);
      else begin m_held = w; m_hold = 1; end
    end
  endfunction

  task automatic tick();
    logic [W-1:0] exp_head;
    @(posedge clock1M);
    model_step();
    #1;
    exp_head = (m_q.size() > 0) ? m_q[0] : '0;
    if (overflow)   ovf_seen  = 1;
    if (parity_err) perr_seen = 1;
    check("m_data_out", data_out, exp_head);
    check("m_count",    count_out, m_q.size());
    check("m_full",     full_out, m_q.size() == D);
    check("m_empty",    empty_out, m_q.size() == 0);
    check("m_status",   status_out, m_hold);
    check("m_overflow", overflow, m_ovf);
    check("m_parity",   parity_err, m_perr);
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    data_in  = b;
    write_in = 1'b1;
    repeat (hi) tick();
    write_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic send_word(input logic [W-1:0] w, input int hi, input int lo, input bit bad_par);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], hi, lo);
`ifdef DESERQ_PARITY_EN
    send_bit((^w) ^ bad_par, hi, lo);
`else
    if (bad_par) $display("note: parity injection has no effect without DESERQ_PARITY_EN");
`endif
  endtask

  task automatic pulse_deq();
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    tick();
  endtask

  typedef struct {
    bit           deq_first;
    int           exp_cnt_pop;
    logic [W-1:0] word;
    int           hi;
    int           lo;
    logic [W-1:0] exp_head;
    int           exp_count;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 0, 8'hA5, 10, 10, 8'hA5, 1};
    vecs[1] = '{1, 0, 8'h3C,  1,  1, 8'h3C, 1};
    vecs[2] = '{0, 0, 8'h01,  3,  2, 8'h3C, 2};
    vecs[3] = '{1, 1, 8'h32,  1,  1, 8'h01, 2};
    vecs[4] = '{0, 0, 8'hCC,  2,  1, 8'h01, 3};
    vecs[5] = '{0, 0, 8'h95,  1,  3, 8'h01, 4};

    // Reset held for 10 cycles.
    reset = 1'b0;
    repeat (10) tick();
    check("rst_data", data_out, 8'h00);
    check("rst_status", status_out, 1'b0);
    check("rst_empty", empty_out, 1'b1);
    check("rst_count", count_out, 0);
    reset = 1'b1;
    tick();

    // Frames from the table, leaving 01,32,CC,95 queued.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].deq_first) begin
        pulse_deq();
        check($sformatf("vec%0d_pop_count", i), count_out, vecs[i].exp_cnt_pop);
        if (vecs[i].exp_cnt_pop == 0) check($sformatf("vec%0d_pop_data", i), data_out, 8'h00);
      end
      send_word(vecs[i].word, vecs[i].hi, vecs[i].lo, 1'b0);
      check($sformatf("vec%0d_head", i), data_out, vecs[i].exp_head);
      check($sformatf("vec%0d_count", i), count_out, vecs[i].exp_count);
    end
    check("t4_full", full_out, 1'b1);

    // Fifth frame stalls in HOLD; an extra strobe is dropped.
    send_word(8'hA5, 1, 1, 1'b0);
    check("t4_status_hold", status_out, 1'b1);
    check("t4_count_hold", count_out, 4);
    ovf_seen = 0;
    write_in = 1'b1;
    tick();
    check("t4_overflow_pulse", overflow, 1'b1);
    write_in = 1'b0;
    tick();
    check("t4_overflow_clear", overflow, 1'b0);
    check("t4_overflow_seen", ovf_seen, 1'b1);
    dequeue_in = 1'b1;
    tick();
    check("t4_pop_head", data_out, 8'h32);
    check("t4_pop_count", count_out, 4);
    check("t4_pop_status", status_out, 1'b0);
    dequeue_in = 1'b0;
    tick();
    repeat (3) pulse_deq();
    check("t4_last_head", data_out, 8'hA5);
    check("t4_last_count", count_out, 1);

    // Drain to empty, then pop while empty.
    pulse_deq();
    check("t3_empty", empty_out, 1'b1);
    check("t3_empty_data", data_out, 8'h00);
    pulse_deq();
    check("t3_underflow_count", count_out, 0);

    // Reset mid-frame discards the partial bits.
    send_bit(1'b1, 1, 1);
    send_bit(1'b0, 1, 1);
    send_bit(1'b1, 1, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    send_word(8'hA5, 1, 1, 1'b0);
    check("t5_head", data_out, 8'hA5);
    check("t5_count", count_out, 1);

`ifdef DESERQ_PARITY_EN
    send_word(8'hA5, 1, 1, 1'b0);
    check("t6_good_count", count_out, 2);
    perr_seen = 0;
    send_word(8'hA5, 1, 1, 1'b1);
    check("t6_perr_seen", perr_seen, 1'b1);
    check("t6_bad_count", count_out, 2);
`else
    // The ninth bit opens the next frame: A5, then 0 + 0111100 -> 3C.
    send_word(8'hA5, 1, 1, 1'b0);
    send_bit(1'b0, 1, 1);
    check("t6_mid_count", count_out, 2);
    for (int i = 6; i >= 0; i--) begin
      logic [W-1:0] nxt;
      nxt = 8'h3C;
      send_bit(nxt[i], 1, 1);
    end
    check("t6_count", count_out, 3);
    check("t6_perr_tied", parity_err, 1'b0);
    pulse_deq();
    pulse_deq();
    check("t6_second_frame", data_out, 8'h3C);
`endif

    // Random traffic, including occasional resets and pops into HOLD.
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 399) != 0);
      write_in   = $urandom_range(0, 1);
      data_in    = $urandom_range(0, 1);
      dequeue_in = ($urandom_range(0, 5) == 0);
      tick();
    end
    reset = 1'b1;
    write_in = 1'b0;
    dequeue_in = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
